hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS datapath. Sequences the IF/ID and ID/EX pipeline registers and the PC. Generates:
- load-use stall bubbles;
- taken-branch/jump flushes;
- multi-cycle freezes while a mul/div instruction occupies EX.

Also keeps two saturating performance counters (stall cycles, flush events) for debug readout.

---
 rtl/hazard_if.sv | 34 +++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller:
// hazard sources from ID/EX and the stall/flush/hold controls sent back.
interface hazard_if;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_usesRt;
    logic        ID_isMD;
    logic        EX_MemRead;
    logic [4:0]  EX_rt;
    logic        EX_BranchTaken;

    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        ID_EX_Hold;
    logic        EX_MEM_Flush;
    logic        md_busy;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;

    modport master (
        output ID_rs, ID_rt, ID_usesRt, ID_isMD, EX_MemRead, EX_rt, EX_BranchTaken,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Flush,
        input  md_busy, state, stall_cycles, flush_events
    );

    modport slave (
        input  ID_rs, ID_rt, ID_usesRt, ID_isMD, EX_MemRead, EX_rt, EX_BranchTaken,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Flush,
        output md_busy, state, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: load-use bubbles, taken
// branch flushes, multi-cycle mul/div freezes and saturating debug counters.
module hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    hazard_if.slave hz
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MD_BUSY    = 2'd2
    } state_e;

    localparam logic [3:0] MD_INIT  = 4'(MD_LATENCY - 32'd1);
    localparam logic       MD_MULTI = (MD_LATENCY > 32'd1);

    state_e      state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    logic load_haz_s;
    logic br_flush_s;
    logic pc_write_s;
    logic if_id_write_s;
    logic if_id_flush_s;
    logic id_ex_flush_s;
    logic id_ex_hold_s;
    logic ex_mem_flush_s;
    logic md_busy_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // The ID instruction needs the register the EX load has not produced yet.
    always_comb begin
        load_haz_s = hz.EX_MemRead && (hz.EX_rt != 5'd0) &&
                     ((hz.EX_rt == hz.ID_rs) || (hz.ID_usesRt && (hz.EX_rt == hz.ID_rt)));
    end

    // Next state and pipeline controls; reset forces the pipeline empty.
    always_comb begin
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        id_ex_hold_s   = 1'b0;
        ex_mem_flush_s = 1'b0;
        md_busy_s      = 1'b0;
        br_flush_s     = 1'b0;
        case (state_q)
            RUN, LOAD_STALL: begin
                if (hz.EX_BranchTaken) begin
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    br_flush_s    = 1'b1;
                    state_d       = RUN;
                end else if ((state_q == RUN) && load_haz_s) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    id_ex_flush_s = 1'b1;
                    state_d       = LOAD_STALL;
                end else if ((state_q == RUN) && hz.ID_isMD && MD_MULTI) begin
                    md_cnt_d = MD_INIT;
                    state_d  = MD_BUSY;
                end else begin
                    state_d = RUN;
                end
            end
            MD_BUSY: begin
                pc_write_s     = 1'b0;
                if_id_write_s  = 1'b0;
                id_ex_hold_s   = 1'b1;
                ex_mem_flush_s = 1'b1;
                md_busy_s      = 1'b1;
                // A zero count can only come from corruption; leave MD_BUSY rather than wrap.
                if (md_cnt_q <= 4'd1) begin
                    md_cnt_d = 4'd0;
                    state_d  = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 4'd1;
                    state_d  = MD_BUSY;
                end
            end
            default: begin
                md_cnt_d = 4'd0;
                state_d  = RUN;
            end
        endcase
        if (!rst_n) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            id_ex_hold_s   = 1'b0;
            ex_mem_flush_s = 1'b1;
            md_busy_s      = 1'b0;
            br_flush_s     = 1'b0;
            md_cnt_d       = 4'd0;
            state_d        = RUN;
        end else begin
            md_cnt_d = md_cnt_d;
        end
    end

    // Debug counters: frozen-PC cycles and taken-branch flushes, saturating.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!rst_n) begin
            stall_d = 16'd0;
            flush_d = 16'd0;
        end else begin
            if (!pc_write_s) begin
                stall_d = sat_inc(stall_q);
            end else begin
                stall_d = stall_q;
            end
            if (br_flush_s) begin
                flush_d = sat_inc(flush_q);
            end else begin
                flush_d = flush_q;
            end
        end
    end

    // State, mul/div countdown and counters, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= 4'd0;
            stall_q  <= 16'd0;
            flush_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign hz.PCWrite      = pc_write_s;
    assign hz.IF_ID_Write  = if_id_write_s;
    assign hz.IF_ID_Flush  = if_id_flush_s;
    assign hz.ID_EX_Flush  = id_ex_flush_s;
    assign hz.ID_EX_Hold   = id_ex_hold_s;
    assign hz.EX_MEM_Flush = ex_mem_flush_s;
    assign hz.md_busy      = md_busy_s;
    assign hz.state        = state_q;
    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (MD_LATENCY 4, 1, 16) share one input
// stream and are each checked against a cycle-level model of the hazard rules.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0] in_rs, in_rt, in_ex_rt;
    logic       in_usesrt, in_ismd, in_memread, in_br;

    hazard_if hif4 ();
    hazard_if hif1 ();
    hazard_if hif16 ();

    hazard_ctrl #(.MD_LATENCY(4))  dut4  (.clk(clk), .rst_n(rst_n), .hz(hif4));
    hazard_ctrl #(.MD_LATENCY(1))  dut1  (.clk(clk), .rst_n(rst_n), .hz(hif1));
    hazard_ctrl #(.MD_LATENCY(16)) dut16 (.clk(clk), .rst_n(rst_n), .hz(hif16));

    assign {hif4.ID_rs, hif4.ID_rt, hif4.ID_usesRt, hif4.ID_isMD, hif4.EX_MemRead, hif4.EX_rt, hif4.EX_BranchTaken} =
           {in_rs, in_rt, in_usesrt, in_ismd, in_memread, in_ex_rt, in_br};
    assign {hif1.ID_rs, hif1.ID_rt, hif1.ID_usesRt, hif1.ID_isMD, hif1.EX_MemRead, hif1.EX_rt, hif1.EX_BranchTaken} =
           {in_rs, in_rt, in_usesrt, in_ismd, in_memread, in_ex_rt, in_br};
    assign {hif16.ID_rs, hif16.ID_rt, hif16.ID_usesRt, hif16.ID_isMD, hif16.EX_MemRead, hif16.EX_rt, hif16.EX_BranchTaken} =
           {in_rs, in_rt, in_usesrt, in_ismd, in_memread, in_ex_rt, in_br};

    // Observed vector: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Flush, md_busy, state, stall, flush}
    logic [40:0] obs [3];
    assign obs[0] = {hif4.PCWrite, hif4.IF_ID_Write, hif4.IF_ID_Flush, hif4.ID_EX_Flush, hif4.ID_EX_Hold,
                     hif4.EX_MEM_Flush, hif4.md_busy, hif4.state, hif4.stall_cycles, hif4.flush_events};
    assign obs[1] = {hif1.PCWrite, hif1.IF_ID_Write, hif1.IF_ID_Flush, hif1.ID_EX_Flush, hif1.ID_EX_Hold,
                     hif1.EX_MEM_Flush, hif1.md_busy, hif1.state, hif1.stall_cycles, hif1.flush_events};
    assign obs[2] = {hif16.PCWrite, hif16.IF_ID_Write, hif16.IF_ID_Flush, hif16.ID_EX_Flush, hif16.ID_EX_Hold,
                     hif16.EX_MEM_Flush, hif16.md_busy, hif16.state, hif16.stall_cycles, hif16.flush_events};

    // Reference model: remaining freeze cycles, whether the last cycle was a load bubble, and plain counts.
    int unsigned lat [3] = '{4, 1, 16};
    int          busy_left [3];
    bit          stall_mode [3];
    int          m_sc [3];
    int          m_fe [3];
    logic [40:0] snap [3];
    logic [40:0] expv [3];
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic bit load_haz();
        return in_memread && (in_ex_rt != 5'd0) &&
               ((in_ex_rt == in_rs) || (in_usesrt && (in_ex_rt == in_rt)));
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses, input logic md,
                         input logic mr, input logic [4:0] ert, input logic br);
        in_rs = rs; in_rt = rt; in_usesrt = uses; in_ismd = md;
        in_memread = mr; in_ex_rt = ert; in_br = br;
    endtask

    // One clock: predict and snapshot this cycle's outputs, then advance the model across the edge.
    task automatic step();
        logic [6:0] c;
        logic [1:0] st;
        #2;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n)                             c = 7'b0011010;
            else if (busy_left[k] > 0)              c = 7'b0000111;
            else if (in_br)                         c = 7'b1111000;
            else if (!stall_mode[k] && load_haz())  c = 7'b0001000;
            else                                    c = 7'b1100000;
            st = (busy_left[k] > 0) ? 2'd2 : (stall_mode[k] ? 2'd1 : 2'd0);
            expv[k] = {c, st, 16'(m_sc[k]), 16'(m_fe[k])};
            snap[k] = obs[k];
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                busy_left[k] = 0; stall_mode[k] = 1'b0; m_sc[k] = 0; m_fe[k] = 0;
            end else begin
                if (!expv[k][40] && m_sc[k] < 65535) m_sc[k]++;
                if (busy_left[k] == 0 && in_br && m_fe[k] < 65535) m_fe[k]++;
                if (busy_left[k] > 0) busy_left[k]--;
                else if (in_br) stall_mode[k] = 1'b0;
                else if (!stall_mode[k] && load_haz()) stall_mode[k] = 1'b1;
                else begin
                    if (!stall_mode[k] && in_ismd && lat[k] > 1) busy_left[k] = int'(lat[k]) - 1;
                    stall_mode[k] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, 1'b1, 1'b1, 5'd7, 1'($urandom_range(0, 1)));
            step();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (snap[k][40:34] !== 7'b0011010) begin
                    n_fail++; $display("FAIL reset_outputs dut%0d: got %b want 0011010", k, snap[k][40:34]);
                end
            end
        end
        rst_n = 1'b1;
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (snap[k][33:0] !== 34'd0 || snap[k] !== expv[k]) begin
                n_fail++; $display("FAIL reset_release dut%0d: got %b want %b", k, snap[k], expv[k]);
            end
        end
    endtask

    task automatic test_load_use();
        drive(5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
        step();
        n_cmp++;
        if (snap[0][40:32] !== 9'b000100000) begin
            n_fail++; $display("FAIL load_use_detect: got %b want 000100000", snap[0][40:32]);
        end
        drive(5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (snap[k] !== expv[k]) begin
                    n_fail++; $display("FAIL load_use_seq%0d dut%0d: got %b want %b", i, k, snap[k], expv[k]);
                end
            end
        end
        n_cmp++;
        if (snap[0][33:32] !== 2'd0 || snap[0][31:16] !== 16'd1) begin
            n_fail++; $display("FAIL load_use_count: got state %0d stall %0d want 0 1", snap[0][33:32], snap[0][31:16]);
        end
        // rt=0 never stalls; rt match only matters when the instruction reads rt.
        drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0); step();
        n_cmp++;
        if (snap[0][40] !== 1'b1) begin
            n_fail++; $display("FAIL load_use_r0: got PCWrite %b want 1", snap[0][40]);
        end
        drive(5'd4, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0); step();
        n_cmp++;
        if (snap[0] !== expv[0] || snap[0][40] !== 1'b1) begin
            n_fail++; $display("FAIL load_use_rt_unused: got %b want %b", snap[0], expv[0]);
        end
        drive(5'd4, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0); step();
        n_cmp++;
        if (snap[0] !== expv[0] || snap[0][40] !== 1'b0) begin
            n_fail++; $display("FAIL load_use_rt_used: got %b want %b", snap[0], expv[0]);
        end
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); step();
    endtask

    task automatic test_branch_vs_load();
        drive(5'd8, 5'd3, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1);
        step();
        n_cmp++;
        if (snap[0][40:34] !== 7'b1111000 || snap[0] !== expv[0]) begin
            n_fail++; $display("FAIL branch_wins: got %b want %b", snap[0], expv[0]);
        end
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (snap[k] !== expv[k] || snap[k][15:0] !== 16'd1) begin
                n_fail++; $display("FAIL branch_count dut%0d: got %b want %b", k, snap[k], expv[k]);
            end
        end
    endtask

    task automatic test_muldiv();
        int sc0;
        sc0 = m_sc[0];
        drive(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        step();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ((i < 3 && snap[0][40:32] !== 9'b000011110) || (i == 3 && snap[0][40:32] !== 9'b110000000)) begin
                n_fail++; $display("FAIL muldiv_cycle%0d: got %b", i, snap[0][40:32]);
            end
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (snap[k] !== expv[k]) begin
                    n_fail++; $display("FAIL muldiv_model%0d dut%0d: got %b want %b", i, k, snap[k], expv[k]);
                end
            end
        end
        n_cmp++;
        if (int'(snap[0][31:16]) !== sc0 + 3) begin
            n_fail++; $display("FAIL muldiv_stalls: got %0d want %0d", snap[0][31:16], sc0 + 3);
        end
        for (int i = 0; i < 13; i++) begin
            step();
            n_cmp++;
            if (snap[2] !== expv[2]) begin
                n_fail++; $display("FAIL muldiv_long%0d: got %b want %b", i, snap[2], expv[2]);
            end
        end
    endtask

    task automatic test_reset_mid_md();
        drive(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0); step();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); step();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (snap[0][40:34] !== 7'b0011010) begin
            n_fail++; $display("FAIL reset_mid_md_forced: got %b want 0011010", snap[0][40:34]);
        end
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (snap[k] !== expv[k] || snap[k][40:32] !== 9'b110000000) begin
                n_fail++; $display("FAIL reset_mid_md_after dut%0d: got %b want %b", k, snap[k], expv[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0));
            step();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (snap[k] !== expv[k]) begin
                    n_fail++; $display("FAIL random%0d dut%0d: got %b want %b", i, k, snap[k], expv[k]);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        rst_n = 1'b1;
        // Back-to-back mul/divs freeze the MD_LATENCY=16 instance 15 cycles out of 16.
        drive(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 70500; i++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (snap[k] !== expv[k]) begin
                    n_fail++; $display("FAIL saturation%0d dut%0d: got %b want %b", i, k, snap[k], expv[k]);
                end
            end
        end
        n_cmp++;
        if (snap[2][31:16] !== 16'hFFFF) begin
            n_fail++; $display("FAIL saturation_hold: got %h want ffff", snap[2][31:16]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_vs_load();
        test_muldiv();
        test_reset_mid_md();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
